// File: rtl/code_mem_server.sv
// code_mem_server
//   Responder end of the instruction-cache code interface. Each 32-bit code
//   word is fetched from a 16-bit asynchronous code memory as two halfword
//   reads (low half, then high half), each stretched by W wait states.
//
//   Optional feature macro: CODE_PREFETCH_EN
//     When defined, a delivered word whose address is not the last word of
//     an 8-word line immediately starts a speculative fetch of the next word.
//     The speculative word is only delivered if the requester still asks for
//     that address when its high half completes.
//
// Ports
//   clk        single clock
//   rst        synchronous active-high reset
//   code_rd    line-fill request, held for the whole burst
//   code_addr  word address (ADDRLEN-2 bits)
//   code_valid one-cycle pulse, code_data valid in that cycle
//   code_data  fetched word {high half, low half}; holds between pulses
//   wait_cfg   wait states per halfword access
//   mem_rd     memory output enable
//   mem_addr   halfword address to the code memory
//   mem_rdata  memory read data
module code_mem_server #(
   parameter int ADDRLEN = 24,
   parameter int WAITW   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               code_rd,
   input  logic [ADDRLEN-3:0] code_addr,
   output logic               code_valid,
   output logic [31:0]        code_data,
   input  logic [WAITW-1:0]   wait_cfg,
   output logic               mem_rd,
   output logic [ADDRLEN-2:0] mem_addr,
   input  logic [15:0]        mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      VALID
   } state_t;

   state_t             state, state_nxt;
   logic [ADDRLEN-3:0] a, a_nxt;
   logic [WAITW-1:0]   w, w_nxt;
   logic [WAITW-1:0]   cnt, cnt_nxt;
   logic [31:0]        data_nxt;
   logic               deliver;

`ifdef CODE_PREFETCH_EN
   // A speculative word is only handed over if the requester still wants
   // exactly the address being fetched.
   assign deliver = code_rd && (code_addr == a);
`else
   assign deliver = code_rd;
`endif

   // Halfword address: the word address with the half select in bit 0.
   assign mem_addr = {a, (state == HI)};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a         <= '0;
         w         <= '0;
         cnt       <= '0;
         code_data <= '0;
      end else begin
         state     <= state_nxt;
         a         <= a_nxt;
         w         <= w_nxt;
         cnt       <= cnt_nxt;
         code_data <= data_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      a_nxt      = a;
      w_nxt      = w;
      cnt_nxt    = cnt;
      data_nxt   = code_data;
      code_valid = 1'b0;
      mem_rd     = 1'b0;

      case (state)
         IDLE: begin
            if (code_rd) begin
               a_nxt     = code_addr;
               w_nxt     = wait_cfg;
               cnt_nxt   = wait_cfg;
               state_nxt = LO;
            end
         end

         LO: begin
            mem_rd = 1'b1;
            if (cnt == '0) begin
               data_nxt[15:0] = mem_rdata;
               cnt_nxt        = w;
               state_nxt      = HI;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end

         HI: begin
            mem_rd = 1'b1;
            if (cnt == '0) begin
               // The high half is captured even when the word is discarded.
               data_nxt[31:16] = mem_rdata;
               state_nxt       = deliver ? VALID : IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end

         VALID: begin
            code_valid = 1'b1;
            state_nxt  = IDLE;
`ifdef CODE_PREFETCH_EN
            if (a[2:0] != 3'b111) begin
               a_nxt     = a + 1'b1;
               cnt_nxt   = w;
               state_nxt = LO;
            end
`endif
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/code_mem_server.md
Name: code_mem_server

Overview:
- Responder end of the instruction-cache code interface (code_rd / code_addr / code_valid / code_data).
- Serves 32-bit instruction words from a 16-bit asynchronous code memory (parallel flash or SRAM) with programmable wait states.
- Each word is fetched as two halfword reads: low half first, then high half.
- Sits between the instruction cache's line-fill port and the external code memory pins.

Parameters:
- ADDRLEN, 24: byte address width of the code space. code_addr is a word address of ADDRLEN-2 bits.
- WAITW, 4: width of the wait-state configuration field.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous active-high reset.
- code_rd  in  1  line-fill request from the cache; held high for the whole burst.
- code_addr  in  ADDRLEN-2  word address; the requester advances it on the edge that samples code_valid.
- code_valid  out  1  one-cycle pulse; code_data is valid in that cycle.
- code_data  out  32  fetched word, {high half, low half}.
- wait_cfg  in  WAITW  wait states W per halfword access.
- mem_rd  out  1  memory output enable.
- mem_addr  out  ADDRLEN-1  halfword address.
- mem_rdata  in  16  memory read data.

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE; code_valid=0; code_data=0; mem_rd=0; mem_addr=0; internal word address and wait counter=0.
- Reset asserted mid-access returns to IDLE on the next edge. No code_valid is produced for the aborted word.
- States: IDLE, LO, HI, VALID.
- IDLE: mem_rd=0.
  - If code_rd=1: latch A=code_addr and W=wait_cfg, load counter=W, go to LO.
- LO: mem_rd=1, mem_addr={A,0}.
  - Counter decrements each cycle.
  - At the edge where counter==0: capture mem_rdata into code_data[15:0], reload counter=W, go to HI.
- HI: mem_rd=1, mem_addr={A,1}.
  - At the edge where counter==0: capture code_data[31:16].
  - Then go to VALID if code_rd=1, else go to IDLE (word discarded).
- VALID: code_valid=1 for exactly this one cycle; mem_rd=0; next state IDLE.
- Each halfword occupies W+1 cycles, with mem_addr stable for all of them. mem_rdata is sampled only on the final edge.
- Latency: for an IDLE cycle t0 with code_rd=1, code_valid is high in cycle t0+2W+3.
- Back-to-back words: the IDLE cycle after VALID samples the updated code_addr. Beat period is 2W+4 cycles.
- Bursts: no burst counter inside the block. The requester sequences 8 words and drops code_rd after the word at A[2:0]=7.
- code_rd dropped mid-word: the memory access completes, no code_valid is produced, and code_data keeps the captured halves.
- wait_cfg changes take effect only at the next latch point in IDLE.
- code_data holds its value between pulses.
- Address arithmetic wraps modulo 2^(ADDRLEN-2) words.

Optional Feature:
- Macro: CODE_PREFETCH_EN.
- When defined:
  - From VALID, if A[2:0]!=7, latch A=A+1, load counter=W and go straight to LO, skipping IDLE. This is a speculative fetch.
  - At the end of HI, go to VALID only if code_rd=1 and code_addr==A; otherwise go to IDLE and discard.
  - If A[2:0]==7, VALID goes to IDLE as normal.
  - Beat period within a line becomes 2W+3 cycles. First-word latency is unchanged.
- When undefined: VALID always goes to IDLE, and the prefetch compare logic is absent.

Test Plan:
1. Reset: assert rst for 2 cycles with code_rd=1 -> code_valid=0, mem_rd=0, mem_addr=0, code_data=0.
2. W=0, code_rd rises at t0 with code_addr=0x100, memory returns halfword value = halfword address -> code_valid at t0+3 and t0+7 (t0+6 with CODE_PREFETCH_EN). First beat data=0x02010200. 8 beats total, addresses 0x100..0x107, mem_addr sequence 0x200,0x201,...
3. W=3, single word at code_addr=0x3FF -> mem_addr=0x7FE held 4 cycles, then 0x7FF held 4 cycles; code_valid at t0+9; data {mem[0x7FF],mem[0x7FE]}.
4. W=2, code_rd dropped during HI -> no code_valid pulse; block returns to IDLE; next request is served normally from IDLE.
5. rst pulsed during LO of word 3 of a burst -> IDLE next cycle, no code_valid; a new request afterwards shows full first-word latency.
6. CODE_PREFETCH_EN, W=1: after word at A=0x15, requester changes code_addr to 0x40 -> prefetch of 0x16 discarded with no code_valid; 0x40 delivered 2W+3=5 cycles after IDLE resample. After the word at A[2:0]=7 no mem_rd is issued.
